// File: rtl/fifo_rd_pkg.sv
// Shared types, defaults and pointer-coding helpers for the async FIFO read side.
// Build option: define FIFO_RD_FWFT_EN for first-word-fall-through reads.
package fifo_rd_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Widest pointer the helpers handle; narrower pointers are zero-extended in.
  localparam int MAX_PW = 32;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

`ifdef FIFO_RD_FWFT_EN
  localparam rd_mode_e RD_MODE = RD_FWFT;
`else
  localparam rd_mode_e RD_MODE = RD_STD;
`endif

  function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Leading zeros from zero-extension decode to zeros, so any PW <= MAX_PW works.
  function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] gray);
    logic [MAX_PW-1:0] bin;
    bin[MAX_PW-1] = gray[MAX_PW-1];
    for (int i = MAX_PW - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_status.sv
// Registered read-side status: level, empty/almost-empty flags, underflow pulse
// and successful-read counter, all derived from the next read pointer.
module fifo_rd_status
  import fifo_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int PW = ADDR_WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [PW-1:0]         i_wbin,
  input  logic [PW-1:0]         i_rbin_n,
  input  logic                  i_held,
  input  logic                  i_count_inc,
  input  logic                  i_underflow,
  input  logic [ADDR_WIDTH-1:0] i_aempty_value,
  output logic [PW-1:0]         o_rd_level,
  output logic                  o_rdempty,
  output logic                  o_rd_almost_empty,
  output logic                  o_underflow,
  output logic [PW-1:0]         o_read_count
);

  logic [PW-1:0] w_level_n;
  logic [PW-1:0] w_aempty_ext;

  logic [PW-1:0] r_rd_level;
  logic          r_rdempty;
  logic          r_rd_almost_empty;
  logic          r_underflow;
  logic [PW-1:0] r_read_count;

  // i_held adds a word already pulled out of the array but not yet consumed.
  assign w_level_n    = i_wbin - i_rbin_n + PW'(i_held);
  assign w_aempty_ext = {1'b0, i_aempty_value};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_level        <= '0;
      r_rdempty         <= 1'b1;
      r_rd_almost_empty <= 1'b1;
      r_underflow       <= 1'b0;
      r_read_count      <= '0;
    end else begin
      r_rd_level        <= w_level_n;
      r_rdempty         <= (w_level_n == '0);
      r_rd_almost_empty <= (w_level_n <= w_aempty_ext);
      r_underflow       <= i_underflow;
      if (i_count_inc) begin
        r_read_count <= r_read_count + 1'b1;
      end
    end
  end

  assign o_rd_level        = r_rd_level;
  assign o_rdempty         = r_rdempty;
  assign o_rd_almost_empty = r_rd_almost_empty;
  assign o_underflow       = r_underflow;
  assign o_read_count      = r_read_count;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller: read pointer, array read port, output register.
// Build option: FIFO_RD_FWFT_EN selects first-word-fall-through presentation.
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int PW = ADDR_WIDTH + 1
) (
  input  logic                  rclk,
  input  logic                  sw_rst,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] aempty_value,
  input  logic [PW-1:0]         wptr_gray_sync,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  output logic [PW-1:0]         rptr_gray,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  rdata_valid,
  output logic                  rdempty,
  output logic                  rd_almost_empty,
  output logic                  underflow,
  output logic [PW-1:0]         fifo_read_count,
  output logic [PW-1:0]         rd_level
);

  logic [MAX_PW-1:0]     w_wbin_full;
  logic [MAX_PW-1:0]     w_rgray_full;
  logic                  w_unused_ext;
  logic [PW-1:0]         w_wbin;
  logic [PW-1:0]         w_rbin_n;
  logic                  w_avail;
  logic                  w_advance;
  logic                  w_valid_n;
  logic                  w_count_inc;
  logic                  w_underflow;
  logic                  w_held;

  logic [PW-1:0]         r_rbin;
  logic [PW-1:0]         r_rptr_gray;
  logic [DATA_WIDTH-1:0] r_read_data;
  logic                  r_rdata_valid;

  assign w_wbin_full  = gray2bin(MAX_PW'(wptr_gray_sync));
  assign w_wbin       = w_wbin_full[PW-1:0];
  assign w_rgray_full = bin2gray(MAX_PW'(w_rbin_n));
  // Upper helper bits are always zero; fold them away so they count as consumed.
  assign w_unused_ext = ^{w_wbin_full, w_rgray_full};

  assign w_avail = (w_wbin != r_rbin);

`ifdef FIFO_RD_FWFT_EN
  logic w_pop;

  // The output register refills whenever it is empty or being popped this cycle.
  assign w_pop       = read_enable & r_rdata_valid;
  assign w_advance   = (!r_rdata_valid | w_pop) & w_avail;
  assign w_valid_n   = w_advance | (r_rdata_valid & !w_pop);
  assign w_count_inc = w_pop;
  assign w_underflow = read_enable & !r_rdata_valid;
  assign w_held      = w_valid_n;
`else
  assign w_advance   = read_enable & w_avail;
  assign w_valid_n   = w_advance;
  assign w_count_inc = w_advance;
  assign w_underflow = read_enable & !w_avail;
  assign w_held      = 1'b0;
`endif

  assign w_rbin_n  = r_rbin + PW'(w_advance);
  assign mem_raddr = r_rbin[ADDR_WIDTH-1:0];
  assign mem_ren   = w_advance;

  always_ff @(posedge rclk) begin
    if (sw_rst) begin
      r_rbin        <= '0;
      r_rptr_gray   <= '0;
      r_read_data   <= '0;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rbin        <= w_rbin_n;
      r_rptr_gray   <= w_rgray_full[PW-1:0];
      r_rdata_valid <= w_valid_n;
      if (w_advance) begin
        r_read_data <= mem_rdata;
      end
    end
  end

  fifo_rd_status #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_status (
    .i_clk             (rclk),
    .i_rst             (sw_rst),
    .i_wbin            (w_wbin),
    .i_rbin_n          (w_rbin_n),
    .i_held            (w_held),
    .i_count_inc       (w_count_inc),
    .i_underflow       (w_underflow),
    .i_aempty_value    (aempty_value),
    .o_rd_level        (rd_level),
    .o_rdempty         (rdempty),
    .o_rd_almost_empty (rd_almost_empty),
    .o_underflow       (underflow),
    .o_read_count      (fifo_read_count)
  );

  assign rptr_gray   = r_rptr_gray;
  assign read_data   = r_read_data;
  assign rdata_valid = r_rdata_valid;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl at 32-bit x 32-deep; the storage array and the
// write pointer are modelled here, expected values are hand-derived constants.
module tb_fifo_rd_ctrl;
  import fifo_rd_pkg::*;

  logic        rclk;
  logic        sw_rst;
  logic        read_enable;
  logic [4:0]  aempty_value;
  logic [5:0]  wptr_gray_sync;
  logic [31:0] mem_rdata;
  logic [4:0]  mem_raddr;
  logic        mem_ren;
  logic [5:0]  rptr_gray;
  logic [31:0] read_data;
  logic        rdata_valid;
  logic        rdempty;
  logic        rd_almost_empty;
  logic        underflow;
  logic [5:0]  fifo_read_count;
  logic [5:0]  rd_level;

  logic [31:0] mem [32];
  logic [5:0]  wbin;
  int          vecCount;
  int          missCount;

  fifo_rd_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .rclk            (rclk),
    .sw_rst          (sw_rst),
    .read_enable     (read_enable),
    .aempty_value    (aempty_value),
    .wptr_gray_sync  (wptr_gray_sync),
    .mem_rdata       (mem_rdata),
    .mem_raddr       (mem_raddr),
    .mem_ren         (mem_ren),
    .rptr_gray       (rptr_gray),
    .read_data       (read_data),
    .rdata_valid     (rdata_valid),
    .rdempty         (rdempty),
    .rd_almost_empty (rd_almost_empty),
    .underflow       (underflow),
    .fifo_read_count (fifo_read_count),
    .rd_level        (rd_level)
  );

  assign mem_rdata      = mem[mem_raddr];
  assign wptr_gray_sync = wbin ^ (wbin >> 1);

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  function automatic logic [5:0] g2b(input logic [5:0] g);
    logic [5:0] b;
    b[5] = g[5];
    for (int i = 4; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // The write side must never lead the read pointer by more than the depth.
  always @(posedge rclk) begin
    if (!sw_rst) begin
      assert (6'(wbin - g2b(rptr_gray)) <= 6'd32)
        else $error("[TB] write pointer leads read pointer by more than depth");
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic resetDut();
    sw_rst = 1'b1;
    read_enable = 1'b0;
    wbin = 6'd0;
    tick();
    sw_rst = 1'b0;
  endtask

  task automatic test_reset();
    sw_rst = 1'b1;
    read_enable = 1'b1;
    wbin = 6'd7;
    tick();
    tick();
    vecCount++; if (rptr_gray !== 6'd0) begin missCount++; $display("[TB] FAIL reset_rptr: got %0d want 0", rptr_gray); end
    vecCount++; if (rdempty !== 1'b1) begin missCount++; $display("[TB] FAIL reset_empty: got %b want 1", rdempty); end
    vecCount++; if (rd_almost_empty !== 1'b1) begin missCount++; $display("[TB] FAIL reset_aempty: got %b want 1", rd_almost_empty); end
    vecCount++; if (underflow !== 1'b0) begin missCount++; $display("[TB] FAIL reset_underflow: got %b want 0", underflow); end
    vecCount++; if (fifo_read_count !== 6'd0) begin missCount++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_read_count); end
    vecCount++; if (rd_level !== 6'd0) begin missCount++; $display("[TB] FAIL reset_level: got %0d want 0", rd_level); end
    vecCount++; if (read_data !== 32'd0) begin missCount++; $display("[TB] FAIL reset_data: got %h want 0", read_data); end
    vecCount++; if (rdata_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid: got %b want 0", rdata_valid); end
    wbin = 6'd0;
    read_enable = 1'b0;
    tick();
    sw_rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    resetDut();
    aempty_value = 5'd2;
    for (int k = 0; k < 4; k++) begin
      mem[wbin[4:0]] = 32'hA0 + 32'(k);
      wbin = wbin + 6'd1;
      tick();
      if (k == 0) begin
        vecCount++; if (rdempty !== 1'b0) begin missCount++; $display("[TB] FAIL first_write_empty: got %b want 0", rdempty); end
        vecCount++; if (rd_level !== 6'd1) begin missCount++; $display("[TB] FAIL first_write_level: got %0d want 1", rd_level); end
      end
    end
    vecCount++; if (rd_level !== 6'd4) begin missCount++; $display("[TB] FAIL fill_level: got %0d want 4", rd_level); end
    vecCount++; if (rd_almost_empty !== 1'b0) begin missCount++; $display("[TB] FAIL fill_aempty: got %b want 0", rd_almost_empty); end
    for (int i = 0; i < 4; i++) begin
      read_enable = 1'b1;
      #1;
      if (i == 0) begin
        vecCount++; if (mem_ren !== 1'b1 || mem_raddr !== 5'd0) begin missCount++; $display("[TB] FAIL drain_port: got ren=%b addr=%0d want ren=1 addr=0", mem_ren, mem_raddr); end
      end
      tick();
      vecCount++; if (read_data !== 32'hA0 + 32'(i)) begin missCount++; $display("[TB] FAIL drain_data%0d: got %h want %h", i, read_data, 32'hA0 + 32'(i)); end
      vecCount++; if (rdata_valid !== 1'b1) begin missCount++; $display("[TB] FAIL drain_valid%0d: got %b want 1", i, rdata_valid); end
      vecCount++; if (rd_level !== 6'(3 - i)) begin missCount++; $display("[TB] FAIL drain_level%0d: got %0d want %0d", i, rd_level, 3 - i); end
      vecCount++; if (rd_almost_empty !== ((3 - i) <= 2)) begin missCount++; $display("[TB] FAIL drain_aempty%0d: got %b want %b", i, rd_almost_empty, ((3 - i) <= 2)); end
    end
    vecCount++; if (rdempty !== 1'b1) begin missCount++; $display("[TB] FAIL drain_empty: got %b want 1", rdempty); end
    vecCount++; if (fifo_read_count !== 6'd4) begin missCount++; $display("[TB] FAIL drain_count: got %0d want 4", fifo_read_count); end
    read_enable = 1'b0;
    tick();
    vecCount++; if (rdata_valid !== 1'b0) begin missCount++; $display("[TB] FAIL drain_valid_drop: got %b want 0", rdata_valid); end
  endtask

  // Continues from the drained state of test_fill_drain: pointers both at 4.
  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      read_enable = 1'b1;
      tick();
      vecCount++; if (underflow !== 1'b1) begin missCount++; $display("[TB] FAIL uflow_pulse%0d: got %b want 1", i, underflow); end
      vecCount++; if (fifo_read_count !== 6'd4) begin missCount++; $display("[TB] FAIL uflow_count%0d: got %0d want 4", i, fifo_read_count); end
      vecCount++; if (read_data !== 32'hA3) begin missCount++; $display("[TB] FAIL uflow_data%0d: got %h want a3", i, read_data); end
      vecCount++; if (rptr_gray !== 6'd6) begin missCount++; $display("[TB] FAIL uflow_rptr%0d: got %0d want 6", i, rptr_gray); end
      vecCount++; if (rdata_valid !== 1'b0) begin missCount++; $display("[TB] FAIL uflow_valid%0d: got %b want 0", i, rdata_valid); end
    end
    read_enable = 1'b0;
    tick();
    vecCount++; if (underflow !== 1'b0) begin missCount++; $display("[TB] FAIL uflow_clear: got %b want 0", underflow); end
  endtask

  task automatic test_wrap();
    resetDut();
    for (int p = 0; p < 40; p++) begin
      mem[wbin[4:0]] = 32'hC000_0000 + 32'(p);
      wbin = wbin + 6'd1;
      read_enable = 1'b0;
      tick();
      vecCount++; if (rdempty !== 1'b0) begin missCount++; $display("[TB] FAIL wrap_empty%0d: got %b want 0", p, rdempty); end
      read_enable = 1'b1;
      tick();
      vecCount++; if (read_data !== 32'hC000_0000 + 32'(p) || underflow !== 1'b0) begin missCount++; $display("[TB] FAIL wrap_read%0d: got %h uf=%b want %h uf=0", p, read_data, underflow, 32'hC000_0000 + 32'(p)); end
      if (p == 30) begin
        vecCount++; if (rptr_gray !== 6'd16) begin missCount++; $display("[TB] FAIL wrap_gray31: got %0d want 16", rptr_gray); end
      end
      if (p == 31) begin
        vecCount++; if (rptr_gray !== 6'd48) begin missCount++; $display("[TB] FAIL wrap_gray32: got %0d want 48", rptr_gray); end
      end
    end
    read_enable = 1'b0;
    vecCount++; if (fifo_read_count !== 6'd40) begin missCount++; $display("[TB] FAIL wrap_count: got %0d want 40", fifo_read_count); end
  endtask

  task automatic test_full_level();
    resetDut();
    aempty_value = 5'd2;
    for (int i = 0; i < 32; i++) mem[i] = 32'hB000_0000 + 32'(i);
    wbin = 6'd32;
    tick();
    vecCount++; if (rd_level !== 6'd32) begin missCount++; $display("[TB] FAIL full_level: got %0d want 32", rd_level); end
    vecCount++; if (rdempty !== 1'b0) begin missCount++; $display("[TB] FAIL full_empty: got %b want 0", rdempty); end
    vecCount++; if (rd_almost_empty !== 1'b0) begin missCount++; $display("[TB] FAIL full_aempty: got %b want 0", rd_almost_empty); end
    read_enable = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      vecCount++; if (read_data !== 32'hB000_0000 + 32'(i)) begin missCount++; $display("[TB] FAIL full_data%0d: got %h want %h", i, read_data, 32'hB000_0000 + 32'(i)); end
    end
    read_enable = 1'b0;
    vecCount++; if (rdempty !== 1'b1) begin missCount++; $display("[TB] FAIL full_drained: got %b want 1", rdempty); end
    vecCount++; if (fifo_read_count !== 6'd32) begin missCount++; $display("[TB] FAIL full_count: got %0d want 32", fifo_read_count); end
  endtask

  task automatic test_back_to_back();
    resetDut();
    mem[0] = 32'hD1D1_0001;
    wbin = 6'd1;
    tick();
    mem[1] = 32'hD2D2_0002;
    wbin = 6'd2;
    read_enable = 1'b1;
    tick();
    vecCount++; if (rd_level !== 6'd1) begin missCount++; $display("[TB] FAIL b2b_level: got %0d want 1", rd_level); end
    vecCount++; if (read_data !== 32'hD1D1_0001) begin missCount++; $display("[TB] FAIL b2b_data0: got %h want d1d10001", read_data); end
    tick();
    vecCount++; if (read_data !== 32'hD2D2_0002 || rdata_valid !== 1'b1) begin missCount++; $display("[TB] FAIL b2b_data1: got %h v=%b want d2d20002 v=1", read_data, rdata_valid); end
    vecCount++; if (rdempty !== 1'b1) begin missCount++; $display("[TB] FAIL b2b_empty: got %b want 1", rdempty); end
    read_enable = 1'b0;
  endtask

  task automatic test_fwft();
    resetDut();
    aempty_value = 5'd0;
    mem[0] = 32'h55;
    wbin = 6'd1;
    tick();
    vecCount++; if (rdata_valid !== 1'b1 || read_data !== 32'h55) begin missCount++; $display("[TB] FAIL fwft_present: got v=%b %h want v=1 55", rdata_valid, read_data); end
    vecCount++; if (rdempty !== 1'b0 || rd_level !== 6'd1) begin missCount++; $display("[TB] FAIL fwft_status: got e=%b lvl=%0d want e=0 lvl=1", rdempty, rd_level); end
    read_enable = 1'b1;
    tick();
    vecCount++; if (rdempty !== 1'b1 || rdata_valid !== 1'b0) begin missCount++; $display("[TB] FAIL fwft_pop: got e=%b v=%b want e=1 v=0", rdempty, rdata_valid); end
    vecCount++; if (fifo_read_count !== 6'd1) begin missCount++; $display("[TB] FAIL fwft_count: got %0d want 1", fifo_read_count); end
    tick();
    vecCount++; if (underflow !== 1'b1) begin missCount++; $display("[TB] FAIL fwft_uflow: got %b want 1", underflow); end
    read_enable = 1'b0;
  endtask

  initial begin
    vecCount = 0;
    missCount = 0;
    sw_rst = 1'b1;
    read_enable = 1'b0;
    aempty_value = 5'd2;
    wbin = 6'd0;
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    $display("[TB] read mode %s", RD_MODE.name());
    test_reset();
`ifdef FIFO_RD_FWFT_EN
    test_fwft();
`else
    test_fill_drain();
    test_underflow();
    test_wrap();
    test_full_level();
    test_back_to_back();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
